// File: rtl/aes_sbox_pkg.sv
// Shared types and helpers for the shuffled S-box generator.
// Holds the FSM states, the default LFSR taps and the range-mask helper.
package aes_sbox_pkg;

   localparam int unsigned MAX_W = 16;
   localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SHUFFLE,
      INVERT,
      DONE
   } state_e;

   // Smallest all-ones value >= i; callers truncate to their own width.
   function automatic logic [MAX_W-1:0] range_mask(input logic [MAX_W-1:0] i);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int b = 0; b < MAX_W; b++) begin
         if (m < i) m = {m[MAX_W-2:0], 1'b1};
      end
      return m;
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with loadable state.
// Resets to all-ones; load takes priority over step.
module lfsr_galois #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_val;
      end else if (step) begin
         state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= '1;
      else       state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/aes_sbox_shuffle_gen.sv
// Randomised bijective S-box: identity fill, Fisher-Yates shuffle, inverse build.
// Multi-lane combinational lookup, gated to zero until the tables are complete.
module aes_sbox_shuffle_gen
   import aes_sbox_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      LANES     = 4,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS),
   parameter bit               INV_EN    = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH-1:0]       seed,
   input  logic                   inv_sel,
   input  logic [LANES*WIDTH-1:0] word_in,
   output logic                   busy,
   output logic                   ready,
   output logic [LANES*WIDTH-1:0] word_out
);

   localparam int unsigned N = 2**WIDTH;

   typedef logic [WIDTH-1:0] sym_t;

   state_e state_q, state_d;
   sym_t   idx_q, idx_d;
   logic   busy_q, busy_d;
   logic   ready_q, ready_d;

   sym_t fwd_q [N];
   sym_t inv_q [N];

   sym_t lfsr, lfsr_seed, mask, cand;
   logic lfsr_load, lfsr_step, do_swap;

   assign lfsr_seed = (seed == '0) ? '1 : seed;
   assign mask      = sym_t'(range_mask(MAX_W'(idx_q)));
   assign cand      = lfsr & mask;

   lfsr_galois #(
      .WIDTH (WIDTH),
      .TAPS  (LFSR_TAPS)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .load     (lfsr_load),
      .load_val (lfsr_seed),
      .step     (lfsr_step),
      .state    (lfsr)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      do_swap   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               lfsr_load = 1'b1;
               idx_d     = '0;
               state_d   = INIT;
            end
         end
         INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == sym_t'(N-1)) begin
               idx_d   = sym_t'(N-1);
               state_d = SHUFFLE;
            end
         end
         SHUFFLE: begin
            lfsr_step = 1'b1;
            if (cand <= idx_q) begin
               do_swap = 1'b1;
               idx_d   = idx_q - 1'b1;
               if (idx_q == sym_t'(1)) begin
                  idx_d   = '0;
                  state_d = INV_EN ? INVERT : DONE;
               end
            end
         end
         INVERT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == sym_t'(N-1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d == INIT) || (state_d == SHUFFLE)
             || (state_d == INVERT);
      ready_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   // Table storage is deliberately unreset; ready_q hides stale contents.
   always_ff @(posedge clk) begin
      if (state_q == INIT) fwd_q[idx_q] <= idx_q;
      if (do_swap) begin
         fwd_q[idx_q] <= fwd_q[cand];
         fwd_q[cand]  <= fwd_q[idx_q];
      end
      if (state_q == INVERT) inv_q[fwd_q[idx_q]] <= idx_q;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sym_t sym;
      assign sym = word_in[k*WIDTH +: WIDTH];
      assign word_out[k*WIDTH +: WIDTH] =
         !ready_q              ? '0 :
         (INV_EN && inv_sel)   ? inv_q[sym] :
                                 fwd_q[sym];
   end

   assign busy  = busy_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_aes_sbox_shuffle_gen.sv
// Randomised bench for the shuffled S-box generator against a table-level model.
// Covers 8-bit/4-lane with inverse and 4-bit/2-lane forward-only builds.
module tb_aes_sbox_shuffle_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start4;
   logic [7:0]  seed8;
   logic [3:0]  seed4;
   logic        inv8, inv4;
   logic [31:0] win8, wout8;
   logic [7:0]  win4, wout4;
   logic        busy8, ready8, busy4, ready4;

   int n_chk  = 0;
   int n_pass = 0;

   int m_fwd [256];
   int m_inv [256];
   int m_rej, m_lat;
   int obs   [256];
   int t1    [256];
   int tA    [256];
   int first_busy, first_ready;

   always #5 clk = ~clk;

   aes_sbox_shuffle_gen dut8 (
      .clk      (clk),
      .reset    (rst),
      .start    (start8),
      .seed     (seed8),
      .inv_sel  (inv8),
      .word_in  (win8),
      .busy     (busy8),
      .ready    (ready8),
      .word_out (wout8)
   );

   aes_sbox_shuffle_gen #(
      .WIDTH     (4),
      .LANES     (2),
      .LFSR_TAPS (4'h9),
      .INV_EN    (1'b0)
   ) dut4 (
      .clk      (clk),
      .reset    (rst),
      .start    (start4),
      .seed     (seed4),
      .inv_sel  (inv4),
      .word_in  (win4),
      .busy     (busy4),
      .ready    (ready4),
      .word_out (wout4)
   );

   // Fisher-Yates over plain integers, driven by the LFSR recurrence.
   task automatic run_model(input int w, input int taps, input int sd,
                            input bit inv_en);
      int n, lf, i, cand, mask, t, guard;
      n = 1 << w;
      lf = (sd == 0) ? n - 1 : sd;
      for (int k = 0; k < n; k++) m_fwd[k] = k;
      m_rej = 0;
      i = n - 1;
      guard = 0;
      while (i >= 1 && guard < 100000) begin
         mask = 1;
         while (mask < i) mask = mask * 2 + 1;
         cand = lf & mask;
         lf = (lf & 1) ? ((lf >> 1) ^ taps) : (lf >> 1);
         if (cand <= i) begin
            t = m_fwd[i];
            m_fwd[i] = m_fwd[cand];
            m_fwd[cand] = t;
            i--;
         end else begin
            m_rej++;
         end
         guard++;
      end
      for (int k = 0; k < n; k++) m_inv[m_fwd[k]] = k;
      m_lat = 1 + n + (n - 1 + m_rej) + (inv_en ? n : 0);
   endtask

   task automatic begin_run(input bit d4, input int sd);
      @(negedge clk);
      if (d4) begin start4 = 1'b1; seed4 = 4'(sd); end
      else    begin start8 = 1'b1; seed8 = 8'(sd); end
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      start4 = 1'b0;
   endtask

   // Cycle 0 is the start cycle; returns -1 when the budget expires.
   task automatic wait_ready(input bit d4, input int pulse_at, output int lat);
      int cyc;
      cyc = 1;
      lat = -1;
      first_busy  = d4 ? int'(busy4)  : int'(busy8);
      first_ready = d4 ? int'(ready4) : int'(ready8);
      while (cyc < 3000) begin
         if ((d4 ? ready4 : ready8) === 1'b1) begin
            lat = cyc;
            break;
         end
         if (cyc == pulse_at) begin
            start8 = 1'b1;
            seed8  = 8'h55;
         end
         @(negedge clk);
         start8 = 1'b0;
         cyc++;
      end
   endtask

   task automatic read_tbl(input bit d4, input bit inv);
      int n, lanes, q, r, sym;
      n = d4 ? 16 : 256;
      lanes = d4 ? 2 : 4;
      q = n / lanes;
      for (int b = 0; b < q; b++) begin
         @(negedge clk);
         r = $urandom_range(0, lanes - 1);
         inv4 = inv;
         inv8 = inv;
         for (int k = 0; k < lanes; k++) begin
            sym = b + q * ((k + r) % lanes);
            if (d4) win4[k*4 +: 4] = 4'(sym);
            else    win8[k*8 +: 8] = 8'(sym);
         end
         #1;
         for (int k = 0; k < lanes; k++) begin
            sym = b + q * ((k + r) % lanes);
            obs[sym] = d4 ? int'(wout4[k*4 +: 4]) : int'(wout8[k*8 +: 8]);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start8 = 1'b1; start4 = 1'b1;
      seed8 = 8'h01; seed4 = 4'h1;
      inv8 = 1'b0; inv4 = 1'b0;
      win8 = $urandom; win4 = 8'($urandom);
      repeat (3) @(negedge clk);
      n_chk++;
      if ({busy8, ready8} !== 2'b00) $display("FAIL reset8_flags got %b want 00", {busy8, ready8});
      else n_pass++;
      n_chk++;
      if (wout8 !== 32'h0) $display("FAIL reset8_word got %h want 0", wout8);
      else n_pass++;
      n_chk++;
      if ({busy4, ready4, wout4} !== 10'h0) $display("FAIL reset4 got %b want 0", {busy4, ready4, wout4});
      else n_pass++;
      start8 = 1'b0; start4 = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (busy8 !== 1'b0) $display("FAIL reset_wins_start got busy=%b want 0", busy8);
      else n_pass++;
   endtask

   task automatic test_forward;
      int lat, dups;
      bit seen [256];
      run_model(8, 'hB8, 1, 1'b1);
      begin_run(1'b0, 1);
      wait_ready(1'b0, -1, lat);
      n_chk++;
      if (first_busy !== 1) $display("FAIL fwd_busy_next got %0d want 1", first_busy);
      else n_pass++;
      n_chk++;
      if (lat !== m_lat) $display("FAIL fwd_latency got %0d want %0d", lat, m_lat);
      else n_pass++;
      read_tbl(1'b0, 1'b0);
      dups = 0;
      for (int x = 0; x < 256; x++) seen[x] = 1'b0;
      for (int x = 0; x < 256; x++) begin
         if (seen[obs[x] & 255]) dups++;
         seen[obs[x] & 255] = 1'b1;
         t1[x] = obs[x];
      end
      n_chk++;
      if (dups !== 0) $display("FAIL fwd_permutation got dups=%0d want 0", dups);
      else n_pass++;
      for (int x = 0; x < 256; x++) begin
         n_chk++;
         if (obs[x] !== m_fwd[x]) $display("FAIL fwd_entry[%0d] got %0d want %0d", x, obs[x], m_fwd[x]);
         else n_pass++;
      end
   endtask

   task automatic test_inverse;
      int x [4];
      int got;
      inv8 = 1'b1;
      for (int b = 0; b < 64; b++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            x[k] = (b + 64 * k + $urandom_range(0, 255)) & 255;
            win8[k*8 +: 8] = 8'(m_fwd[x[k]]);
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            got = int'(wout8[k*8 +: 8]);
            n_chk++;
            if (got !== x[k]) $display("FAIL inv_roundtrip lane%0d got %0d want %0d", k, got, x[k]);
            else n_pass++;
         end
      end
      read_tbl(1'b0, 1'b1);
      for (int y = 0; y < 256; y++) begin
         n_chk++;
         if (obs[y] !== m_inv[y]) $display("FAIL inv_entry[%0d] got %0d want %0d", y, obs[y], m_inv[y]);
         else n_pass++;
      end
   endtask

   task automatic test_start_ignored;
      int lat, bad;
      run_model(8, 'hB8, 1, 1'b1);
      begin_run(1'b0, 1);
      wait_ready(1'b0, 400, lat);
      n_chk++;
      if (first_ready !== 0) $display("FAIL restart_ready_falls got %0d want 0", first_ready);
      else n_pass++;
      n_chk++;
      if (lat !== m_lat) $display("FAIL ignored_latency got %0d want %0d", lat, m_lat);
      else n_pass++;
      read_tbl(1'b0, 1'b0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (obs[x] !== m_fwd[x]) bad++;
      n_chk++;
      if (bad !== 0) $display("FAIL ignored_table got %0d diffs want 0", bad);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int lat, bad;
      begin_run(1'b0, 1);
      repeat (400) @(negedge clk);
      n_chk++;
      if (busy8 !== 1'b1) $display("FAIL mid_busy got %b want 1", busy8);
      else n_pass++;
      win8 = 32'hA5C3_0F81;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({busy8, ready8, wout8} !== 34'h0) $display("FAIL mid_reset got b=%b r=%b w=%h want 0", busy8, ready8, wout8);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      run_model(8, 'hB8, 1, 1'b1);
      begin_run(1'b0, 1);
      wait_ready(1'b0, -1, lat);
      n_chk++;
      if (lat !== m_lat) $display("FAIL mid_restart_latency got %0d want %0d", lat, m_lat);
      else n_pass++;
      read_tbl(1'b0, 1'b0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (obs[x] !== t1[x]) bad++;
      n_chk++;
      if (bad !== 0) $display("FAIL mid_restart_table got %0d diffs want 0", bad);
      else n_pass++;
   endtask

   task automatic test_seeds;
      int lat, bad;
      begin_run(1'b0, 0);
      wait_ready(1'b0, -1, lat);
      read_tbl(1'b0, 1'b0);
      for (int x = 0; x < 256; x++) tA[x] = obs[x];
      run_model(8, 'hB8, 255, 1'b1);
      begin_run(1'b0, 255);
      wait_ready(1'b0, -1, lat);
      n_chk++;
      if (lat !== m_lat) $display("FAIL seedFF_latency got %0d want %0d", lat, m_lat);
      else n_pass++;
      read_tbl(1'b0, 1'b0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (obs[x] !== tA[x]) bad++;
      n_chk++;
      if (bad !== 0) $display("FAIL seed00_vs_FF got %0d diffs want 0", bad);
      else n_pass++;
      run_model(8, 'hB8, 2, 1'b1);
      begin_run(1'b0, 2);
      wait_ready(1'b0, -1, lat);
      read_tbl(1'b0, 1'b0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (obs[x] !== t1[x]) bad++;
      n_chk++;
      if (bad == 0) $display("FAIL seed02_vs_01 got 0 diffs want nonzero");
      else n_pass++;
      bad = 0;
      for (int x = 0; x < 256; x++) if (obs[x] !== m_fwd[x]) bad++;
      n_chk++;
      if (bad !== 0) $display("FAIL seed02_table got %0d diffs want 0", bad);
      else n_pass++;
   endtask

   task automatic test_random_seeds;
      int lat, bad, sd;
      for (int r = 0; r < 3; r++) begin
         sd = $urandom_range(1, 255);
         run_model(8, 'hB8, sd, 1'b1);
         begin_run(1'b0, sd);
         wait_ready(1'b0, -1, lat);
         n_chk++;
         if (lat !== m_lat) $display("FAIL rand_latency seed=%0d got %0d want %0d", sd, lat, m_lat);
         else n_pass++;
         read_tbl(1'b0, 1'b1);
         bad = 0;
         for (int y = 0; y < 256; y++) if (obs[y] !== m_inv[y]) bad++;
         n_chk++;
         if (bad !== 0) $display("FAIL rand_inv seed=%0d got %0d diffs want 0", sd, bad);
         else n_pass++;
      end
   endtask

   task automatic test_w4;
      int lat, bad, dups, sd;
      int seeds [3];
      bit seen [16];
      seeds[0] = 0;
      seeds[1] = 5;
      seeds[2] = $urandom_range(1, 15);
      for (int s = 0; s < 3; s++) begin
         sd = seeds[s];
         run_model(4, 'h9, sd, 1'b0);
         begin_run(1'b1, sd);
         wait_ready(1'b1, -1, lat);
         n_chk++;
         if (first_busy !== 1) $display("FAIL w4_busy seed=%0d got %0d want 1", sd, first_busy);
         else n_pass++;
         n_chk++;
         if (lat !== m_lat) $display("FAIL w4_latency seed=%0d got %0d want %0d", sd, lat, m_lat);
         else n_pass++;
         read_tbl(1'b1, 1'b0);
         bad = 0;
         dups = 0;
         for (int x = 0; x < 16; x++) seen[x] = 1'b0;
         for (int x = 0; x < 16; x++) begin
            if (obs[x] !== m_fwd[x]) bad++;
            if (seen[obs[x] & 15]) dups++;
            seen[obs[x] & 15] = 1'b1;
         end
         n_chk++;
         if (bad !== 0 || dups !== 0) $display("FAIL w4_table seed=%0d got diffs=%0d dups=%0d want 0", sd, bad, dups);
         else n_pass++;
         read_tbl(1'b1, 1'b1);
         bad = 0;
         for (int x = 0; x < 16; x++) if (obs[x] !== m_fwd[x]) bad++;
         n_chk++;
         if (bad !== 0) $display("FAIL w4_invsel_fwd seed=%0d got %0d diffs want 0", sd, bad);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_start_ignored();
      test_reset_mid();
      test_seeds();
      test_random_seeds();
      test_w4();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
